bram_mem_responder: RTL
=======================

# bram_mem_responder

On-chip memory responder for the slave end of the cache-to-memory request/response channel: it accepts line read and write requests from the cache side and answers reads with line data from block RAM. It is a drop-in replacement for the DDR2 controller in simulation and in board bring-up without the MIG. A programmable wait count lets it mimic DRAM latency, so the cache controller's miss handling is exercised realistically.

## Interface
Parameters:
- LINE_W, 128, line width in bits (multiple of 8)
- DEPTH_LOG2, 10, log2 of the number of lines stored
- LATENCY, 4, extra wait cycles before each read is serviced (0 allowed)

Ports:
- clk  in  1  single clock for all logic
- rstn  in  1  reset, synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request this cycle
- req_cmd  in  1  1 = read, 0 = write
- req_addr  in  27  byte address; line index = req_addr[log2(LINE_W/8)+DEPTH_LOG2-1 : log2(LINE_W/8)]
- req_wdata  in  LINE_W  write line data
- req_wmask  in  LINE_W/8  per-byte write enable, 1 = write byte
- rsp_valid  out  1  read data valid
- rsp_ready  in  1  requester takes read data
- rsp_rdata  out  LINE_W  read line data
- addr_err  out  1  sticky: an accepted address had nonzero bits above the line index

## Operation
- Handshake: a request is accepted on a rising edge where req_valid && req_ready. A response is consumed on an edge where rsp_valid && rsp_ready. Inputs are sampled only at acceptance.
- req_ready = rstn && (state == IDLE). It is combinational from the state register.
- FSM states: IDLE, WAIT, RESP.
  - IDLE, write accepted: the masked bytes are written to the indexed line at that edge, and the state stays IDLE. Back-to-back writes run at 1 per cycle. Writes produce no response.
  - IDLE, read accepted: latch the line index, set cnt = LATENCY, go to WAIT.
  - WAIT, cnt != 0: cnt decrements by 1.
  - WAIT, cnt == 0: the latched index drives the synchronous BRAM read. At the edge, rsp_rdata is loaded from the BRAM output, rsp_valid is set to 1, and the state goes to RESP.
  - RESP: rsp_valid and rsp_rdata are held stable until rsp_ready. On the consuming edge, rsp_valid goes to 0 and the state returns to IDLE.
- At most one read is outstanding. No new request is accepted in WAIT or RESP.
- Address: bits below the line index are ignored. Bits above the index are ignored for the access, which wraps modulo 2^DEPTH_LOG2. If any of those upper bits is nonzero on an accepted request, addr_err is set to 1 and stays set until reset.
- Read-after-write: a read accepted any cycle after a write's acceptance returns the written data.
- Reset (rstn low at an edge): state goes to IDLE, cnt = 0, rsp_valid = 0, rsp_rdata = 0, addr_err = 0. A pending read is dropped with no response. BRAM contents are not cleared.
- req_ready is 0 while rstn is low. A req_valid asserted during reset is not accepted.

## Timing
- Read accepted at the edge ending cycle T gives rsp_valid = 1 from cycle T+LATENCY+2. The minimum is 2 cycles, at LATENCY = 0.
- With rsp_ready held high, rsp_valid stays high for exactly 1 cycle, and req_ready is high again in cycle T+LATENCY+3.
- Read throughput is one read per LATENCY+3 cycles at best. Write throughput is 1 per cycle.
- Write commit becomes visible to a read whose BRAM access happens in any later cycle.
- Reset values: req_ready = 0 (during reset), then 1. rsp_valid = 0, rsp_rdata = 0, addr_err = 0.

## Test plan
- Write then read, LATENCY = 4: write 0x...DEADBEEF to addr 0x40 with all mask bits set, then read 0x40. Required: rsp_valid rises exactly 6 cycles after the read is accepted, and rsp_rdata = 0x...DEADBEEF.
- Byte mask: line 0x80 preset to 0x00...00, then write 0xFF...FF with mask 0x0001, then read. Required: rsp_rdata = 0x00...00FF.
- Backpressure: hold rsp_ready = 0 for 10 cycles after rsp_valid rises. Required: rsp_valid and rsp_rdata stay stable, req_ready stays 0, and no second request is accepted. Release rsp_ready and check req_ready = 1 in the next cycle.
- Wrap and error: with DEPTH_LOG2 = 10, write A to addr 0x0000010 and B to addr 0x0004010, then read 0x0000010. Required: the read returns B, and addr_err = 1 after the second write.
- Reset mid-read: accept a read, then pull rstn low for 1 edge during WAIT. Required: rsp_valid never rises, state is IDLE, req_ready = 1 after release, addr_err = 0, and previously written data is still readable.
- LATENCY = 0 with back-to-back writes: 8 writes on consecutive cycles, then 8 reads. Required: every write is accepted in a single cycle, and each read's response arrives exactly 2 cycles after its acceptance with the correct data.

Source files
------------

// File: rtl/bram_mem_responder.sv
// Block-RAM line memory that answers cache read/write requests.
// Reads wait a programmable number of cycles to mimic DRAM latency.
module bram_mem_responder #(
    parameter int LINE_W     = 128,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_cmd,
    input  logic [26:0]         req_addr,
    input  logic [LINE_W-1:0]   req_wdata,
    input  logic [LINE_W/8-1:0] req_wmask,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [LINE_W-1:0]   rsp_rdata,
    output logic                addr_err
);

    localparam int BYTES = LINE_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [DEPTH_LOG2-1:0]   rd_idx;
    logic [LINE_W-1:0]       mem [DEPTH];

    logic [DEPTH_LOG2-1:0]   req_idx;
    logic                    req_hi;
    logic                    acc;
    logic                    wr_en;

    assign req_ready = rstn && (state == IDLE);
    assign acc       = req_valid && req_ready;
    assign wr_en     = acc && !req_cmd;
    assign req_idx   = req_addr[OFF_W +: DEPTH_LOG2];
    // Any address bit above the line index flags an out-of-range access.
    assign req_hi    = (req_addr >> (OFF_W + DEPTH_LOG2)) != '0;

    // Storage is never cleared by reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < BYTES; b++) begin
                if (req_wmask[b]) begin
                    mem[req_idx][b*8 +: 8] <= req_wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt       <= '0;
            rd_idx    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            addr_err  <= 1'b0;
        end else begin
            if (acc && req_hi) begin
                addr_err <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (acc && req_cmd) begin
                        rd_idx <= req_idx;
                        cnt    <= CNT_W'(LATENCY);
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        rsp_rdata <= mem[rd_idx];
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
